// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection for an in-order pipeline with one
// multi-cycle execution unit.
//
// Optional feature: define STALL_CNT_EN to build a saturating stall-cycle
// counter on stall_cnt. When it is undefined, stall_cnt is tied to zero.
//
// state  | meaning
// S_IDLE | no multi-cycle op in flight
// S_BUSY | multi-cycle op executing, pend_rd_q result not yet available
// S_DONE | multi-cycle result valid this cycle, forwardable as select 11
module fwd_hazard_unit #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] rs_ex,
  input  logic [NUM_SRC*REG_AW-1:0] rs_id,
  input  logic [REG_AW-1:0]         rd_ex,
  input  logic [REG_AW-1:0]         rd_mem,
  input  logic [REG_AW-1:0]         rd_wb,
  input  logic                      regwrite_ex,
  input  logic                      regwrite_mem,
  input  logic                      regwrite_wb,
  input  logic                      memread_ex,
  input  logic                      mc_start,
  input  logic [REG_AW-1:0]         mc_rd,
  output logic [2*NUM_SRC-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      flush_ex,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [15:0]               stall_cnt
);

  localparam int CNT_W = $clog2(MC_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [REG_AW-1:0]   pend_rd_q, pend_rd_d;
  logic                load_use_hit;
  logic                mc_hit;
  logic                struct_hit;

  // Status outputs are forced low during reset so nothing leaks out of a
  // stale state while the registers are being cleared.
  assign mc_busy    = !rst && (state_q == S_BUSY);
  assign mc_done    = !rst && (state_q == S_DONE);
  assign struct_hit = mc_start && (state_q == S_BUSY);
  assign stall      = !rst && (load_use_hit || mc_hit || struct_hit);
  assign flush_ex   = stall;

  // Compare ID-stage sources against the load in EX and the pending MC result.
  always_comb begin
    load_use_hit = 1'b0;
    mc_hit       = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (memread_ex && regwrite_ex && (rd_ex != '0) &&
          (rd_ex == rs_id[i*REG_AW +: REG_AW]))
        load_use_hit = 1'b1;
      if ((state_q == S_BUSY) && (pend_rd_q != '0) &&
          (pend_rd_q == rs_id[i*REG_AW +: REG_AW]))
        mc_hit = 1'b1;
    end
  end

  // Per-source forwarding select; MEM is youngest, then MC result, then WB.
  always_comb begin
    fwd_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs_ex[i*REG_AW +: REG_AW]))
        fwd_sel[2*i +: 2] = 2'b10;
      else if (mc_done && (pend_rd_q != '0) && (pend_rd_q == rs_ex[i*REG_AW +: REG_AW]))
        fwd_sel[2*i +: 2] = 2'b11;
      else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs_ex[i*REG_AW +: REG_AW]))
        fwd_sel[2*i +: 2] = 2'b01;
    end
  end

  // Multi-cycle tracker next state; a start seen while BUSY is dropped.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_rd_d = pend_rd_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (mc_start) begin
          state_d   = S_BUSY;
          cnt_d     = CNT_W'(MC_LAT - 1);
          pend_rd_d = mc_rd;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Tracker state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pend_rd_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_rd_q <= pend_rd_d;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Count stalled cycles, holding at all-ones.
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 16'hFFFF))
      stall_cnt_q <= stall_cnt_q + 16'd1;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a timeline model.
module tb_fwd_hazard_unit;

  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int LAT  = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NSRC*AW-1:0]   rs_ex, rs_id;
  logic [AW-1:0]        rd_ex, rd_mem, rd_wb, mc_rd;
  logic                 regwrite_ex, regwrite_mem, regwrite_wb, memread_ex, mc_start;
  logic [2*NSRC-1:0]    fwd_sel;
  logic                 stall, flush_ex, mc_busy, mc_done;
  logic [15:0]          stall_cnt;

  int total = 0;
  int bad   = 0;

  fwd_hazard_unit #(.REG_AW(AW), .NUM_SRC(NSRC), .MC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .rs_ex(rs_ex), .rs_id(rs_id),
    .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
    .regwrite_ex(regwrite_ex), .regwrite_mem(regwrite_mem), .regwrite_wb(regwrite_wb),
    .memread_ex(memread_ex), .mc_start(mc_start), .mc_rd(mc_rd),
    .fwd_sel(fwd_sel), .stall(stall), .flush_ex(flush_ex),
    .mc_busy(mc_busy), .mc_done(mc_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NSRC*AW-1:0] rs_ex;
    logic [NSRC*AW-1:0] rs_id;
    logic [AW-1:0]      rd_ex;
    logic [AW-1:0]      rd_mem;
    logic [AW-1:0]      rd_wb;
    logic               rw_ex;
    logic               rw_mem;
    logic               rw_wb;
    logic               memrd;
    logic [2*NSRC-1:0]  exp_fwd;
    logic               exp_stall;
  } vec_t;

  vec_t vecs[10];

  // Reference model: age of the in-flight op in cycles since acceptance (-1 none).
  int          m_age;
  logic [AW-1:0] m_pend;
  int          m_sc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    rs_ex = '0; rs_id = '0; rd_ex = '0; rd_mem = '0; rd_wb = '0; mc_rd = '0;
    regwrite_ex = 1'b0; regwrite_mem = 1'b0; regwrite_wb = 1'b0;
    memread_ex = 1'b0; mc_start = 1'b0;
  endtask

  function automatic vec_t mkv(input logic [9:0] rse, input logic [9:0] rsi,
                               input logic [4:0] rde, input logic [4:0] rdm,
                               input logic [4:0] rdw, input logic rwe, input logic rwm,
                               input logic rww, input logic mr, input logic [3:0] ef,
                               input logic es);
    vec_t v;
    v.rs_ex = rse; v.rs_id = rsi; v.rd_ex = rde; v.rd_mem = rdm; v.rd_wb = rdw;
    v.rw_ex = rwe; v.rw_mem = rwm; v.rw_wb = rww; v.memrd = mr;
    v.exp_fwd = ef; v.exp_stall = es;
    return v;
  endfunction

  function automatic logic [AW-1:0] fld(input logic [NSRC*AW-1:0] bus, input int i);
    return bus[i*AW +: AW];
  endfunction

  function automatic logic m_busy_now();
    return !rst && (m_age >= 0) && (m_age <= LAT - 2);
  endfunction

  function automatic logic m_done_now();
    return !rst && (m_age == LAT - 1);
  endfunction

  function automatic logic m_stall_now();
    logic lu, mh;
    lu = 1'b0; mh = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (memread_ex && regwrite_ex && rd_ex != 0 && rd_ex == fld(rs_id, i)) lu = 1'b1;
      if (m_busy_now() && m_pend != 0 && m_pend == fld(rs_id, i)) mh = 1'b1;
    end
    return !rst && (lu || mh || (mc_start && m_busy_now()));
  endfunction

  function automatic logic [2*NSRC-1:0] m_fwd_now();
    logic [2*NSRC-1:0] f;
    logic [AW-1:0] s;
    f = '0;
    for (int i = 0; i < NSRC; i++) begin
      s = fld(rs_ex, i);
      if (regwrite_mem && rd_mem != 0 && rd_mem == s)      f[2*i +: 2] = 2'b10;
      else if (m_done_now() && m_pend != 0 && m_pend == s) f[2*i +: 2] = 2'b11;
      else if (regwrite_wb && rd_wb != 0 && rd_wb == s)    f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic int sc_exp(input int n);
`ifdef STALL_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  initial begin
    int exp_sc;
    logic st;

    vecs[0] = mkv({5'd0,5'd5}, 10'd0, 5'd0, 5'd5, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0);
    vecs[1] = mkv({5'd0,5'd5}, 10'd0, 5'd0, 5'd0, 5'd5, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0001, 1'b0);
    vecs[2] = mkv({5'd4,5'd3}, 10'd0, 5'd0, 5'd4, 5'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1001, 1'b0);
    vecs[3] = mkv({5'd4,5'd4}, 10'd0, 5'd0, 5'd4, 5'd4, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0101, 1'b0);
    vecs[4] = mkv({5'd0,5'd0}, 10'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
    vecs[5] = mkv(10'd0, {5'd7,5'd0}, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);
    vecs[6] = mkv(10'd0, {5'd7,5'd0}, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    vecs[7] = mkv(10'd0, {5'd7,5'd0}, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
    vecs[8] = mkv(10'd0, {5'd7,5'd0}, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
    vecs[9] = mkv(10'd0, {5'd0,5'd7}, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1);

    // Reset behaviour: outputs quiet even with hazards and a start request present.
    set_idle();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd0,5'd7};
    mc_start = 1'b1; mc_rd = 5'd9;
    #1;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_flush", 32'(flush_ex), 32'd0);
    chk("rst_busy", 32'(mc_busy), 32'd0);
    chk("rst_done", 32'(mc_done), 32'd0);
    chk("rst_scnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    #1;
    chk("rst_busy2", 32'(mc_busy), 32'd0);
    set_idle();
    rst = 1'b0;
    @(negedge clk);

    // Directed combinational vectors with the tracker idle.
    for (int k = 0; k < 10; k++) begin
      rs_ex = vecs[k].rs_ex; rs_id = vecs[k].rs_id; rd_ex = vecs[k].rd_ex;
      rd_mem = vecs[k].rd_mem; rd_wb = vecs[k].rd_wb; regwrite_ex = vecs[k].rw_ex;
      regwrite_mem = vecs[k].rw_mem; regwrite_wb = vecs[k].rw_wb; memread_ex = vecs[k].memrd;
      #1;
      chk($sformatf("vec%0d_fwd", k), 32'(fwd_sel), 32'(vecs[k].exp_fwd));
      chk($sformatf("vec%0d_stall", k), 32'(stall), 32'(vecs[k].exp_stall));
      chk($sformatf("vec%0d_flush", k), 32'(flush_ex), 32'(vecs[k].exp_stall));
      @(negedge clk);
    end
    set_idle();
    @(negedge clk);

    // MC op: start rd=9, busy two cycles with dependent ID stall, then forward 11.
    mc_start = 1'b1; mc_rd = 5'd9;
    #1 chk("mc_idle_busy", 32'(mc_busy), 32'd0);
    @(negedge clk);
    mc_start = 1'b0; rs_id = {5'd0,5'd9};
    #1;
    chk("mc_b1_busy", 32'(mc_busy), 32'd1);
    chk("mc_b1_done", 32'(mc_done), 32'd0);
    chk("mc_b1_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rs_id = '0;
    #1;
    chk("mc_b2_busy", 32'(mc_busy), 32'd1);
    chk("mc_b2_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rs_ex = {5'd0,5'd9};
    mc_start = 1'b1; mc_rd = 5'd12;
    #1;
    chk("mc_d_done", 32'(mc_done), 32'd1);
    chk("mc_d_busy", 32'(mc_busy), 32'd0);
    chk("mc_d_fwd", 32'(fwd_sel), 32'b0011);
    chk("mc_d_stall", 32'(stall), 32'd0);
    @(negedge clk);
    // Back-to-back op accepted from DONE; hold a conflicting start while BUSY.
    rs_ex = '0; mc_rd = 5'd20;
    #1;
    chk("b2b_busy", 32'(mc_busy), 32'd1);
    chk("b2b_struct_stall", 32'(stall), 32'd1);
    @(negedge clk);
    mc_start = 1'b0;
    #1 chk("b2b_busy2", 32'(mc_busy), 32'd1);
    @(negedge clk);
    rs_ex = {5'd20,5'd12};
    #1;
    chk("b2b_done", 32'(mc_done), 32'd1);
    chk("b2b_fwd_keep_rd", 32'(fwd_sel), 32'b0011);
    @(negedge clk);
    set_idle();
    #1 chk("b2b_idle", 32'(mc_busy | mc_done), 32'd0);

    // Reset mid-operation abandons the op.
    mc_start = 1'b1; mc_rd = 5'd9;
    @(negedge clk);
    mc_start = 1'b0; rst = 1'b1; rs_id = {5'd0,5'd9};
    #1;
    chk("abort_busy_in_rst", 32'(mc_busy), 32'd0);
    chk("abort_stall_in_rst", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("abort_nodone%0d", k), 32'(mc_done | mc_busy), 32'd0);
      @(negedge clk);
    end
    set_idle();

    // Stall counter: 20 load-use cycles, then cleared by reset.
    #1 chk("scnt_start", 32'(stall_cnt), 32'd0);
    memread_ex = 1'b1; regwrite_ex = 1'b1; rd_ex = 5'd7; rs_id = {5'd7,5'd0};
    repeat (20) @(negedge clk);
    set_idle();
    #1 chk("scnt_20", 32'(stall_cnt), 32'(sc_exp(20)));
    @(negedge clk);
    #1 chk("scnt_hold", 32'(stall_cnt), 32'(sc_exp(20)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("scnt_rst", 32'(stall_cnt), 32'd0);
    @(negedge clk);

    // Randomized traffic against the timeline model.
    m_age = -1; m_pend = '0; m_sc = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NSRC; i++) begin
        rs_ex[i*AW +: AW] = AW'($urandom_range(0, 3));
        rs_id[i*AW +: AW] = AW'($urandom_range(0, 3));
      end
      rd_ex  = AW'($urandom_range(0, 3));
      rd_mem = AW'($urandom_range(0, 3));
      rd_wb  = AW'($urandom_range(0, 3));
      mc_rd  = AW'($urandom_range(0, 3));
      regwrite_ex  = 1'($urandom_range(0, 1));
      regwrite_mem = 1'($urandom_range(0, 1));
      regwrite_wb  = 1'($urandom_range(0, 1));
      memread_ex   = ($urandom_range(0, 3) == 0);
      mc_start     = ($urandom_range(0, 2) == 0);
      rst          = ($urandom_range(0, 60) == 0);
      #1;
      st = m_stall_now();
      chk("rnd_fwd", 32'(fwd_sel), 32'(m_fwd_now()));
      chk("rnd_stall", 32'(stall), 32'(st));
      chk("rnd_flush", 32'(flush_ex), 32'(st));
      chk("rnd_busy", 32'(mc_busy), 32'(m_busy_now()));
      chk("rnd_done", 32'(mc_done), 32'(m_done_now()));
      exp_sc = sc_exp(m_sc);
      chk("rnd_scnt", 32'(stall_cnt), 32'(exp_sc));
      // Advance the model to what the next edge produces.
      if (rst) begin
        m_age = -1; m_pend = '0; m_sc = 0;
      end else begin
        if (st && m_sc < 65535) m_sc++;
        if (mc_start && !((m_age >= 0) && (m_age <= LAT - 2))) begin
          m_age = 0; m_pend = mc_rd;
        end else if (m_age >= 0) begin
          m_age++;
          if (m_age > LAT - 1) m_age = -1;
        end
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter REG_AW, default 5, meaning register address width.
REQ-002 SHALL have parameter NUM_SRC, default 2, meaning number of source operands per instruction (range 1..4).
REQ-003 SHALL have parameter MC_LAT, default 3, meaning multi-cycle unit latency in cycles (MC_LAT >= 2).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 rs_ex  in  NUM_SRC*REG_AW  EX-stage source addresses; source i at bits [i*REG_AW +: REG_AW].
REQ-007 rs_id  in  NUM_SRC*REG_AW  ID-stage source addresses, same packing.
REQ-008 rd_ex, rd_mem, rd_wb  in  REG_AW each  destination addresses of the EX, MEM and WB stages.
REQ-009 regwrite_ex, regwrite_mem, regwrite_wb  in  1 each  register-write enables of those stages.
REQ-010 memread_ex  in  1  EX-stage instruction is a load.
REQ-011 mc_start, mc_rd  in  1, REG_AW  multi-cycle op issue strobe and its destination.
REQ-012 fwd_sel  out  2*NUM_SRC  per-source mux select at bits [2i+1:2i]: 00 regfile, 01 WB, 10 MEM, 11 multi-cycle result.
REQ-013 stall, flush_ex  out  1 each  hold PC/IF/ID; bubble into EX.
REQ-014 mc_busy, mc_done  out  1 each  multi-cycle op in flight; result valid this cycle.
REQ-015 stall_cnt  out  16  stall-cycle count (see Configuration).

Function
REQ-016 fwd_sel SHALL be combinational (0-cycle latency) from current inputs and state.
REQ-017 Per source i: select 10 if regwrite_mem, rd_mem != 0 and rd_mem == rs_ex[i]; else 11 if mc_done, pend_rd != 0 and pend_rd == rs_ex[i]; else 01 if regwrite_wb, rd_wb != 0 and rd_wb == rs_ex[i]; else 00.
REQ-018 Address 0 SHALL never forward, stall or be tracked as pending.
REQ-019 Load-use hit: memread_ex, regwrite_ex, rd_ex != 0 and rd_ex equal to any rs_id[i].
REQ-020 MC hit: state BUSY, pend_rd != 0 and pend_rd equal to any rs_id[i].
REQ-021 Structural hit: mc_start asserted while state BUSY; the request SHALL be ignored that cycle (upstream holds it).
REQ-022 stall SHALL equal load-use hit OR MC hit OR structural hit; flush_ex SHALL equal stall.
REQ-023 FSM states IDLE, BUSY, DONE; mc_busy = (BUSY); mc_done = (DONE).
REQ-024 IDLE or DONE with mc_start: go BUSY, load cnt = MC_LAT-1, capture pend_rd = mc_rd; DONE with mc_start therefore gives back-to-back operation.
REQ-025 IDLE or DONE without mc_start: go IDLE.
REQ-026 BUSY: decrement cnt; on cnt == 1 go DONE. mc_done SHALL be high exactly MC_LAT cycles after the accepted mc_start edge.
REQ-027 pend_rd SHALL remain stable from capture until the next accepted mc_start.
REQ-028 cnt SHALL be $clog2(MC_LAT)+1 bits and never wrap below 1 in BUSY.

Reset
REQ-029 While rst is high at a clock edge: state IDLE, cnt 0, pend_rd 0, stall_cnt 0.
REQ-030 While rst is high, stall, flush_ex, mc_busy and mc_done SHALL be 0, and fwd_sel SHALL never be 11.
REQ-031 Reset asserted mid-operation SHALL abandon the in-flight op; no mc_done follows.

Configuration
REQ-032 Macro STALL_CNT_EN defined: stall_cnt increments by 1 on each edge where stall == 1, saturates at 16'hFFFF and holds.
REQ-033 Macro STALL_CNT_EN undefined: stall_cnt SHALL be tied to 16'h0000 with no counter logic; all other behaviour unchanged.

Verification
REQ-034 rd_mem=5/regwrite_mem=1 and rd_wb=5/regwrite_wb=1, rs_ex[0]=5 -> fwd_sel[1:0]=10; same with rd_mem=0 -> 01.
REQ-035 memread_ex=1, rd_ex=7, rs_id[1]=7 -> stall=flush_ex=1 that cycle; with rd_ex=0 -> stall=0.
REQ-036 MC_LAT=3, mc_start with mc_rd=9 at edge 0 -> mc_busy on edges 1-2, mc_done on edge 3; rs_id=9 during BUSY -> stall=1; rs_ex[0]=9 at DONE -> fwd_sel=11.
REQ-037 mc_start held during BUSY -> stall=1 and pend_rd unchanged; mc_start in DONE -> BUSY next cycle with the new rd.
REQ-038 rst pulsed on edge 1 of an MC_LAT=3 op -> IDLE, no mc_done; with STALL_CNT_EN, 20 stall cycles -> stall_cnt=20, and stall_cnt=0 after rst.
